// File: rtl/ahb_rom_ctrl.sv
// -----------------------------------------------------------------------------
// ahb_rom_ctrl
//
// Purpose:
//   AHB-Lite slave front end for a 512x32 synchronous ROM macro. A read
//   produces exactly one ROM_CS rising edge and samples ROM_DO after
//   WAIT_CYCLES strobe cycles. A write is answered with a two-cycle ERROR
//   response, and the ROM is not touched.
//
// Optional feature (macro ROM_CTRL_CACHE_EN):
//   When defined, a last-word tag remembers the word address of the most
//   recent completed read. A read that hits this tag completes in its first
//   data-phase cycle, with no ROM access. When undefined, the tag logic is
//   not built and every read runs the full ROM sequence.
//
// Parameters:
//   ADDR_BITS    ROM word-address width (default 9 -> 512 words)
//   WAIT_CYCLES  cycles ROM_CS is held high before ROM_DO is sampled (1..3)
//
// Ports:
//   HCLK         in   single clock, all logic on its rising edge
//   HRESETn      in   synchronous active-low reset
//   HSEL         in   slave select (address phase)
//   HADDR[31:0]  in   byte address (address phase)
//   HTRANS[1:0]  in   transfer type (address phase)
//   HWRITE       in   write strobe (address phase)
//   HSIZE[2:0]   in   transfer size (ignored, a full word is always returned)
//   HREADY       in   bus ready (address phase accepted when high)
//   HRDATA[31:0] out  read data (data phase)
//   HREADYOUT    out  slave ready (data phase)
//   HRESP        out  slave response, 1 = ERROR (data phase)
//   ROM_NRST     out  registered copy of HRESETn for the ROM macro
//   ROM_CS       out  ROM chip select, one rising edge per ROM read
//   ROM_EN       out  ROM output enable, active low (1 = ROM output high-Z)
//   ROM_AD       out  ROM word address
//   ROM_DO       in   ROM read data
//   o_dbg_state  out  current FSM state encoding, for debug/observation
//
// Handshake:
//   A transfer is taken when HSEL & HTRANS[1] & HREADY is high at an HCLK
//   edge while the slave is in the final cycle of a data phase (or idle),
//   i.e. while HREADYOUT is high. The data phase that follows ends in the
//   cycle where HREADYOUT is high again; HRDATA/HRESP are valid there.
// -----------------------------------------------------------------------------
module ahb_rom_ctrl #(
   parameter int ADDR_BITS   = 9,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 HSEL,
   input  logic [31:0]          HADDR,
   input  logic [1:0]           HTRANS,
   input  logic                 HWRITE,
   input  logic [2:0]           HSIZE,
   input  logic                 HREADY,
   output logic [31:0]          HRDATA,
   output logic                 HREADYOUT,
   output logic                 HRESP,
   output logic                 ROM_NRST,
   output logic                 ROM_CS,
   output logic                 ROM_EN,
   output logic [ADDR_BITS-1:0] ROM_AD,
   input  logic [31:0]          ROM_DO,
   output logic [2:0]           o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_WAIT   = 3'd3,
      S_ERR1   = 3'd4,
      S_ERR2   = 3'd5
   } state_t;

   // The strobe counter starts at WAIT_CYCLES-1 and the ROM data is sampled
   // in the strobe/wait cycle where it reads zero.
   localparam logic [1:0] LP_CNT_INIT = 2'(WAIT_CYCLES - 1);

   state_t                 r_state;
   logic [1:0]             r_cnt;
   logic                   r_cs;
   logic                   r_en;
   logic [ADDR_BITS-1:0]   r_ad;
   logic                   r_nrst;
   logic [31:0]            r_hrdata;
   logic                   r_hreadyout;
   logic                   r_hresp;

   logic                   w_accept;
   logic [ADDR_BITS-1:0]   w_word;
   logic                   w_hit;

   // Upper address bits alias the ROM, byte-lane bits and HSIZE are ignored.
   logic                   w_unused;
   assign w_unused = &{1'b0, HSIZE, HADDR[31:ADDR_BITS+2], HADDR[1:0]};

   assign w_word = HADDR[ADDR_BITS+1:2];

   // New transfers are only taken in a cycle where HREADYOUT is high: idle,
   // the completion cycle of a read (which is the IDLE state) or ERR2.
   assign w_accept = ((r_state == S_IDLE) || (r_state == S_ERR2)) &&
                     HSEL && HTRANS[1] && HREADY;

`ifdef ROM_CTRL_CACHE_EN
   // Last-word tag. HRDATA only changes when a read completes, so while the
   // tag is valid HRDATA still holds the data of the tagged word and a hit
   // can simply leave it in place.
   logic [ADDR_BITS-1:0]   r_tag;
   logic                   r_tag_v;

   assign w_hit = r_tag_v && (r_tag == w_word);
`else
   assign w_hit = 1'b0;
`endif

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_state     <= S_IDLE;
         r_cnt       <= 2'd0;
         r_cs        <= 1'b0;
         r_en        <= 1'b1;
         r_ad        <= '0;
         r_nrst      <= 1'b0;
         r_hrdata    <= 32'd0;
         r_hreadyout <= 1'b1;
         r_hresp     <= 1'b0;
`ifdef ROM_CTRL_CACHE_EN
         r_tag       <= '0;
         r_tag_v     <= 1'b0;
`endif
      end else begin
         r_nrst <= 1'b1;
         case (r_state)
            // Final cycle of a data phase (or no transfer in flight): fall
            // back to idle outputs unless a new transfer is taken right here,
            // which gives back-to-back transfers with no idle bubble.
            S_IDLE, S_ERR2: begin
               r_state     <= S_IDLE;
               r_cs        <= 1'b0;
               r_en        <= 1'b1;
               r_hreadyout <= 1'b1;
               r_hresp     <= 1'b0;
               if (w_accept) begin
                  if (HWRITE) begin
                     r_state     <= S_ERR1;
                     r_hreadyout <= 1'b0;
                     r_hresp     <= 1'b1;
                  end else if (!w_hit) begin
                     // ROM_AD is loaded one cycle before ROM_CS rises and
                     // is held until the next read is taken.
                     r_state     <= S_SETUP;
                     r_ad        <= w_word;
                     r_en        <= 1'b0;
                     r_hreadyout <= 1'b0;
                  end
               end
            end

            S_SETUP: begin
               r_state <= S_STROBE;
               r_cs    <= 1'b1;
               r_en    <= 1'b0;
               r_cnt   <= LP_CNT_INIT;
            end

            S_STROBE, S_WAIT: begin
               if (r_cnt == 2'd0) begin
                  // ROM_DO is only captured here, while ROM_CS is high and
                  // the ROM output is enabled.
                  r_state     <= S_IDLE;
                  r_hrdata    <= ROM_DO;
                  r_cs        <= 1'b0;
                  r_en        <= 1'b1;
                  r_hreadyout <= 1'b1;
`ifdef ROM_CTRL_CACHE_EN
                  r_tag       <= r_ad;
                  r_tag_v     <= 1'b1;
`endif
               end else begin
                  r_state <= S_WAIT;
                  r_cnt   <= r_cnt - 2'd1;
               end
            end

            S_ERR1: begin
               r_state     <= S_ERR2;
               r_hreadyout <= 1'b1;
               r_hresp     <= 1'b1;
            end

            default: begin
               r_state     <= S_IDLE;
               r_cs        <= 1'b0;
               r_en        <= 1'b1;
               r_hreadyout <= 1'b1;
               r_hresp     <= 1'b0;
            end
         endcase
      end
   end

   assign HRDATA      = r_hrdata;
   assign HREADYOUT   = r_hreadyout;
   assign HRESP       = r_hresp;
   assign ROM_NRST    = r_nrst;
   assign ROM_CS      = r_cs;
   assign ROM_EN      = r_en;
   assign ROM_AD      = r_ad;
   assign o_dbg_state = r_state;

endmodule

// File: doc/ahb_rom_ctrl.md
AHB_ROM_CTRL -- requirements
Module: ahb_rom_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 9, ROM word-address width (512 words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 1..3, cycles ROM_CS is held high before ROM_DO is sampled.
REQ-003 SHALL have port HCLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port HRESETn  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports HSEL  input  1, HADDR  input  32, HTRANS  input  2, HWRITE  input  1, HSIZE  input  3, HREADY  input  1, all AHB-Lite address-phase inputs.
REQ-006 SHALL have ports HRDATA  output  32, HREADYOUT  output  1, HRESP  output  1, all AHB-Lite data-phase outputs.
REQ-007 SHALL have ports ROM_NRST  output  1, ROM_CS  output  1, ROM_EN  output  1, ROM_AD  output  ADDR_BITS, ROM_DO  input  32, all connecting to the 512x32 ROM macro.

Function
REQ-008 SHALL treat a transfer as valid when HSEL & HTRANS[1] & HREADY is high at an HCLK edge; IDLE/BUSY and unselected cycles are ignored.
REQ-009 SHALL decode ROM_AD from HADDR[ADDR_BITS+1:2]; upper bits are ignored, so the block aliases; HSIZE is ignored and a full word is returned.
REQ-010 SHALL implement FSM states IDLE, SETUP, STROBE, WAIT, ERR1, ERR2.
REQ-011 Valid read in IDLE, or in the final cycle of any data phase -> SETUP: register ROM_AD, ROM_CS=0, HREADYOUT=0.
REQ-012 SETUP -> STROBE: ROM_CS=1 (the single rising edge per read), ROM_EN=0, wait counter loaded with WAIT_CYCLES-1.
REQ-013 STROBE/WAIT: ROM_CS stays 1, ROM_EN=0, counter decrements; when it reaches 0, HRDATA is registered from ROM_DO and HREADYOUT=1 in the next cycle.
REQ-014 A read data phase SHALL last exactly WAIT_CYCLES+2 cycles, with HREADYOUT high only in the last cycle.
REQ-015 SHALL drive ROM_AD stable from SETUP until after the read completes, so ROM_AD never changes in the same cycle as a ROM_CS rising edge.
REQ-016 Valid write -> ERR1 (HREADYOUT=0, HRESP=1) -> ERR2 (HREADYOUT=1, HRESP=1) -> IDLE, or straight to the next transfer; no ROM_CS pulse is issued.
REQ-017 In IDLE: ROM_CS=0, ROM_EN=1 (ROM output high-Z), HREADYOUT=1, HRESP=0.
REQ-018 HRDATA SHALL hold its last read value outside read completion and is never driven from an unsampled ROM_DO.
REQ-019 A transfer arriving back-to-back in the last data-phase cycle SHALL enter SETUP or ERR1 with no idle bubble.
REQ-020 ROM_NRST SHALL be a registered copy of HRESETn.

Reset
REQ-021 On HRESETn=0 at an HCLK edge the following SHALL apply, aborting any read mid-operation: FSM=IDLE, ROM_CS=0, ROM_EN=1, ROM_AD=0, ROM_NRST=0, HRDATA=0, HREADYOUT=1, HRESP=0, counter=0.
REQ-022 The first read after reset release SHALL start a full access sequence.

Configuration
REQ-023 Macro ROM_CTRL_CACHE_EN defined: the block SHALL keep a last-word register (tag ADDR_BITS, valid bit, cleared on reset); a read whose word address matches a valid tag completes with HREADYOUT=1 in its first data-phase cycle, with no ROM_CS pulse; a miss runs REQ-011..014 and updates the tag.
REQ-024 Macro ROM_CTRL_CACHE_EN undefined: the tag logic SHALL be absent and every read SHALL run the full sequence.

Verification
REQ-025 ROM word 5 = 0xDEADBEEF, WAIT_CYCLES=1, read HADDR=0x14 -> one ROM_CS rise with ROM_AD=5; HRDATA=0xDEADBEEF with HREADYOUT=1 in the 3rd data-phase cycle.
REQ-026 Back-to-back reads 0x0 then 0x7FC -> ROM_AD 0 then 511; two ROM_CS rises; no idle cycle between the data phases.
REQ-027 Write to 0x10 -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1; ROM_CS stays 0; HRDATA unchanged.
REQ-028 HRESETn=0 during WAIT -> next edge gives ROM_CS=0, HREADYOUT=1, HRDATA=0; a subsequent read of 0x14 returns 0xDEADBEEF.
REQ-029 With ROM_CTRL_CACHE_EN, read 0x14 twice -> the second read completes in 1 cycle with no ROM_CS rise; a read of 0x18 misses (full sequence).
REQ-030 HADDR=0x814 (alias) -> ROM_AD=5, data 0xDEADBEEF, HRESP=0.
